dc_port_arbiter: RTL and testbench
==================================

Name: dc_port_arbiter

Overview:
- Shares the banked data cache (NUM_BANKS banks × ROWS words) between NUM_REQ row-granular requesters, e.g. the LD/ST writeback path and a host/debug port.
- Round-robin arbitration with a valid/ready request side and a fixed-latency response side.
- Includes a sequenced dump mode that drains in-flight traffic and then streams every cache row out in bank order 7..0, replacing hierarchical testbench peeks into bank memories.

Parameters:
- NUM_REQ, 2, number of requesters.
- NUM_BANKS, 8, data cache banks; one word per bank per row.
- ROWS, 512, rows per bank.
- WORD_W, 32, bits per bank word.
- Derived: ROW_W = $clog2(ROWS); LINE_W = NUM_BANKS*WORD_W.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  request present.
- req_ready  out  NUM_REQ  request accepted this cycle.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_row  in  NUM_REQ*ROW_W  target row.
- req_wmask  in  NUM_REQ*NUM_BANKS  per-bank write enable.
- req_wdata  in  NUM_REQ*LINE_W  write line; bank b uses bits [b*WORD_W +: WORD_W].
- rsp_valid  out  NUM_REQ  response for requester i.
- rsp_data  out  LINE_W  read line; 0 for write acks.
- dc_en  out  NUM_BANKS  bank enable.
- dc_we  out  NUM_BANKS  bank write enable.
- dc_row  out  ROW_W  shared bank address.
- dc_wdata  out  LINE_W  bank write data.
- dc_rdata  in  LINE_W  bank read data, synchronous, valid 1 cycle after dc_en.
- dump_start  in  1  single-cycle dump request.
- dump_busy  out  1  high from dump acceptance until dump_done.
- dump_valid  out  1  dump beat valid.
- dump_row  out  ROW_W  row index of dump beat.
- dump_data  out  LINE_W  row contents.
- dump_done  out  1  single-cycle pulse after the last beat.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM enters ARB.
  - rr_ptr = 0.
  - Pipeline valids s1 and s2 cleared.
  - Row counter = 0.
  - A dump in progress is aborted without a dump_done.
- FSM states: ARB, DRAIN, RUN, TAIL.
- ARB state:
  - Grant goes to the first i with req_valid[i] set, searching from rr_ptr upward and wrapping.
  - req_ready is one-hot on the granted requester, all 0 if none; it may depend combinationally on req_valid.
  - On a grant, rr_ptr <= (grant+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - Maximum one transaction per cycle.
- Pipeline, handshake at cycle T:
  - T+1: stage s1 drives dc_en = all ones for a read, or = wmask for a write; dc_we = wmask for a write; dc_row; dc_wdata.
  - T+2: stage s2 asserts rsp_valid[id]; rsp_data = dc_rdata for a read, 0 for a write.
  - Back-to-back grants sustain 1 request per cycle.
  - Responses cannot be stalled.
  - Write with wmask = 0: still consumes a slot and still acks; dc_en = 0.
- Dump sequence:
  - dump_start is honoured only in ARB; it is ignored in other states.
  - Once accepted, the FSM goes to DRAIN and dump_busy = 1. dump_start has priority over same-cycle requests, which are not granted.
  - DRAIN: req_ready = 0; wait until s1 and s2 are both empty, then go to RUN with row = 0.
  - RUN: issue one full-line read per cycle for row 0..ROWS-1. dump_valid/dump_row/dump_data appear 2 cycles after issue.
  - After issuing row ROWS-1, go to TAIL. TAIL waits for the final beat, pulses dump_done in the cycle after that beat, clears dump_busy, and returns to ARB.
  - Total time from accepted start: drain cycles + ROWS + 2 cycles to the last beat.
- Row counter: no wrap; it ends at ROWS-1.
- rsp_valid and dump_valid are never asserted in the same cycle.

Optional Feature:
- Macro DC_ARB_PERF_EN.
- When defined:
  - Adds output perf_stall_cnt  NUM_REQ*32.
  - Counter i increments each cycle req_valid[i] && !req_ready[i], saturating at 32'hFFFF_FFFF.
  - Counters clear on rst and do not clear on dump.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package gpgpu_dc_pkg holds NUM_BANKS, ROWS, WORD_W, ROW_W, LINE_W and the FSM state encoding (ARB=0, DRAIN=1, RUN=2, TAIL=3).
- One sub-module, dc_rr_arbiter: parameter NUM_REQ; inputs req and ptr; output one-hot grant. It is purely combinational; rr_ptr stays in the parent.

Test Plan:
- Single read: req 0 reads row 5 with bank b preloaded to 32'h0500_000b → dc_en = 8'hFF at T+1; rsp_valid[0] at T+2 with rsp_data word b = 32'h0500_000b.
- Masked write: req 1 writes row 3, wmask = 8'h81, wdata all 32'hAAAA_AAAA → dc_we = 8'h81; only banks 7 and 0 change; rsp_valid[1] at T+2 with rsp_data = 0.
- Contention: both requesters valid for 6 cycles → grants alternate 0,1,0,1,0,1; each requester gets 3 responses in grant order.
- Dump during traffic: dump_start while s1 and s2 are busy → req_ready = 0 until done; 512 beats with rows 0..511 in order, matching preloaded memory; dump_done one cycle after row 511.
- Reset mid-dump: rst at row 100 → next cycle all outputs 0, no dump_done, a new read is served normally.
- DC_ARB_PERF_EN: req 1 held valid while req 0 wins 4 cycles → perf_stall_cnt[1] = 4.

Source files
------------

// File: rtl/gpgpu_dc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpgpu_dc_pkg
//  Description : Shared geometry and FSM encoding for the data-cache port
//                arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpgpu_dc_pkg;

  localparam int NUM_BANKS = 8;
  localparam int ROWS      = 512;
  localparam int WORD_W    = 32;
  localparam int ROW_W     = $clog2(ROWS);
  localparam int LINE_W    = NUM_BANKS * WORD_W;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2,
    TAIL  = 2'd3
  } dc_state_e;

  // Bank enables for one pipeline slot: reads touch every bank, writes only
  // the masked ones (a zero mask leaves every bank idle).
  function automatic logic [NUM_BANKS-1:0] bank_enable(
    input logic                 we,
    input logic [NUM_BANKS-1:0] wmask
  );
    return we ? wmask : {NUM_BANKS{1'b1}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dc_rr_arbiter
//  Description : Combinational round-robin picker. Grants the first set
//                request at or above ptr, wrapping; the pointer register
//                itself lives in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module dc_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]                              req,
  input  logic [$clog2((NUM_REQ > 1) ? NUM_REQ : 2)-1:0] ptr,
  output logic [NUM_REQ-1:0]                              grant
);

  localparam int PTR_W = $clog2((NUM_REQ > 1) ? NUM_REQ : 2);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Walk the requesters starting at ptr and take the first valid one.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dc_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dc_port_arbiter
//  Description : Round-robin sharing of the banked data cache between
//                NUM_REQ row-granular requesters, with a 2-cycle fixed
//                response latency and a dump mode that drains traffic and
//                streams every cache row out.
//                Optional macro DC_ARB_PERF_EN adds per-requester stall
//                counters on port perf_stall_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module dc_port_arbiter
  import gpgpu_dc_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ROW_W-1:0]     req_row,
  input  logic [NUM_REQ*NUM_BANKS-1:0] req_wmask,
  input  logic [NUM_REQ*LINE_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [LINE_W-1:0]            rsp_data,
  output logic [NUM_BANKS-1:0]         dc_en,
  output logic [NUM_BANKS-1:0]         dc_we,
  output logic [ROW_W-1:0]             dc_row,
  output logic [LINE_W-1:0]            dc_wdata,
  input  logic [LINE_W-1:0]            dc_rdata,
  input  logic                         dump_start,
  output logic                         dump_busy,
  output logic                         dump_valid,
  output logic [ROW_W-1:0]             dump_row,
  output logic [LINE_W-1:0]            dump_data,
`ifdef DC_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0]        perf_stall_cnt,
`endif
  output logic                         dump_done
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  dc_state_e state_q, state_d;

  logic [ID_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_any;
  logic [ID_W-1:0]      grant_id;
  logic                 sel_we;
  logic [ROW_W-1:0]     sel_row;
  logic [NUM_BANKS-1:0] sel_wmask;
  logic [LINE_W-1:0]    sel_wdata;

  logic                 issue_dump;
  logic                 start_run;
  logic                 finish_dump;
  logic [ROW_W-1:0]     row_cnt;
  logic                 dump_done_q;

  // Stage s1: bank access cycle.
  logic                 s1_valid;
  logic                 s1_dump;
  logic                 s1_we;
  logic [ID_W-1:0]      s1_id;
  logic [ROW_W-1:0]     s1_row;
  logic [NUM_BANKS-1:0] s1_wmask;
  logic [LINE_W-1:0]    s1_wdata;

  // Stage s2: read data returns from the banks.
  logic                 s2_valid;
  logic                 s2_dump;
  logic                 s2_we;
  logic [ID_W-1:0]      s2_id;
  logic [ROW_W-1:0]     s2_row;

  dc_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Requests are only accepted in ARB; a same-cycle dump_start wins.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == ARB && !dump_start) begin
      req_ready = grant;
    end
  end

  assign grant_any = |req_ready;

  // Encode the one-hot grant and select that requester's fields.
  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        grant_id = ID_W'(i);
      end
    end
    sel_we    = req_we[grant_id];
    sel_row   = req_row[grant_id*ROW_W +: ROW_W];
    sel_wmask = req_wmask[grant_id*NUM_BANKS +: NUM_BANKS];
    sel_wdata = req_wdata[grant_id*LINE_W +: LINE_W];
  end

  // Next-state logic for the dump sequencer.
  always_comb begin
    state_d     = state_q;
    issue_dump  = 1'b0;
    start_run   = 1'b0;
    finish_dump = 1'b0;
    case (state_q)
      ARB: begin
        if (dump_start) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        issue_dump = 1'b1;
        if (row_cnt == LAST_ROW) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        if (s2_valid && s2_dump && s2_row == LAST_ROW) begin
          state_d     = ARB;
          finish_dump = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin pointer advances past the requester just granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
    end
  end

  // Dump row counter: cleared on entering RUN, stops at the last row.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
    end else if (start_run) begin
      row_cnt <= '0;
    end else if (issue_dump && row_cnt != LAST_ROW) begin
      row_cnt <= row_cnt + 1'b1;
    end
  end

  // Load s1 from either a granted request or a dump read; never both.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dump  <= 1'b0;
      s1_we    <= 1'b0;
      s1_id    <= '0;
      s1_row   <= '0;
      s1_wmask <= '0;
      s1_wdata <= '0;
    end else if (grant_any) begin
      s1_valid <= 1'b1;
      s1_dump  <= 1'b0;
      s1_we    <= sel_we;
      s1_id    <= grant_id;
      s1_row   <= sel_row;
      s1_wmask <= sel_wmask;
      s1_wdata <= sel_wdata;
    end else if (issue_dump) begin
      s1_valid <= 1'b1;
      s1_dump  <= 1'b1;
      s1_we    <= 1'b0;
      s1_id    <= '0;
      s1_row   <= row_cnt;
      s1_wmask <= '0;
      s1_wdata <= '0;
    end else begin
      s1_valid <= 1'b0;
      s1_dump  <= 1'b0;
      s1_we    <= 1'b0;
      s1_id    <= '0;
      s1_row   <= '0;
      s1_wmask <= '0;
      s1_wdata <= '0;
    end
  end

  // s2 simply follows s1; responses cannot stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_dump  <= 1'b0;
      s2_we    <= 1'b0;
      s2_id    <= '0;
      s2_row   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_dump  <= s1_dump;
      s2_we    <= s1_we;
      s2_id    <= s1_id;
      s2_row   <= s1_row;
    end
  end

  // dump_done pulses the cycle after the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_done_q <= 1'b0;
    end else begin
      dump_done_q <= finish_dump;
    end
  end

  assign dc_en    = s1_valid ? bank_enable(s1_we, s1_wmask) : '0;
  assign dc_we    = (s1_valid && s1_we) ? s1_wmask : '0;
  assign dc_row   = s1_valid ? s1_row : '0;
  assign dc_wdata = (s1_valid && s1_we) ? s1_wdata : '0;

  // Route s2 to either the owning requester or the dump stream.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = s2_valid && !s2_dump && (s2_id == ID_W'(i));
    end
  end

  assign rsp_data   = (s2_valid && !s2_dump && !s2_we) ? dc_rdata : '0;
  assign dump_valid = s2_valid && s2_dump;
  assign dump_row   = dump_valid ? s2_row : '0;
  assign dump_data  = dump_valid ? dc_rdata : '0;
  assign dump_busy  = (state_q != ARB);
  assign dump_done  = dump_done_q;

`ifdef DC_ARB_PERF_EN
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
      logic [31:0] stall_cnt;

      // Count cycles where requester i waits; saturate rather than wrap.
      always_ff @(posedge clk) begin
        if (rst) begin
          stall_cnt <= '0;
        end else if (req_valid[i] && !req_ready[i] && stall_cnt != 32'hFFFF_FFFF) begin
          stall_cnt <= stall_cnt + 32'd1;
        end
      end

      assign perf_stall_cnt[i*32 +: 32] = stall_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_dc_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dc_port_arbiter
//  Description : Directed self-checking bench for dc_port_arbiter with a
//                behavioural banked memory on the dc_* side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_port_arbiter;
  import gpgpu_dc_pkg::*;

  localparam int NREQ = 2;

  logic                      clk;
  logic                      rst;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           req_we;
  logic [NREQ*ROW_W-1:0]     req_row;
  logic [NREQ*NUM_BANKS-1:0] req_wmask;
  logic [NREQ*LINE_W-1:0]    req_wdata;
  logic [NREQ-1:0]           rsp_valid;
  logic [LINE_W-1:0]         rsp_data;
  logic [NUM_BANKS-1:0]      dc_en;
  logic [NUM_BANKS-1:0]      dc_we;
  logic [ROW_W-1:0]          dc_row;
  logic [LINE_W-1:0]         dc_wdata;
  logic [LINE_W-1:0]         dc_rdata;
  logic                      dump_start;
  logic                      dump_busy;
  logic                      dump_valid;
  logic [ROW_W-1:0]          dump_row;
  logic [LINE_W-1:0]         dump_data;
  logic                      dump_done;
`ifdef DC_ARB_PERF_EN
  logic [NREQ*32-1:0]        perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [NUM_BANKS][ROWS];
  logic [31:0] exp_mem [NUM_BANKS][ROWS];
  logic [LINE_W-1:0] rdata_q;

  dc_port_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_row        (req_row),
    .req_wmask      (req_wmask),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .dc_en          (dc_en),
    .dc_we          (dc_we),
    .dc_row         (dc_row),
    .dc_wdata       (dc_wdata),
    .dc_rdata       (dc_rdata),
    .dump_start     (dump_start),
    .dump_busy      (dump_busy),
    .dump_valid     (dump_valid),
    .dump_row       (dump_row),
    .dump_data      (dump_data),
`ifdef DC_ARB_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .dump_done      (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Banked synchronous memory: one word per bank, read data next cycle.
  assign dc_rdata = rdata_q;
  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (dc_en[b]) begin
        if (dc_we[b]) mem[b][dc_row] <= dc_wdata[b*WORD_W +: WORD_W];
        else          rdata_q[b*WORD_W +: WORD_W] <= mem[b][dc_row];
      end
    end
  end

  // Row 5 bank b -> 32'h0500_000b; row bit 8 lands in bit 16.
  function automatic logic [31:0] init_word(input int r, input int b);
    logic [8:0] rr;
    logic [3:0] bb;
    rr = r[8:0];
    bb = b[3:0];
    return {rr[7:0], 7'b0, rr[8], 12'h000, bb};
  endfunction

  function automatic logic [LINE_W-1:0] exp_line(input int r);
    logic [LINE_W-1:0] l;
    for (int b = 0; b < NUM_BANKS; b++) l[b*WORD_W +: WORD_W] = exp_mem[b][r];
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_we     = '0;
    req_row    = '0;
    req_wmask  = '0;
    req_wdata  = '0;
    dump_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    checks++; if (dc_en !== 8'h00 || dc_we !== 8'h00 || dc_row !== '0 || dc_wdata !== '0) begin
      errors++; $display("FAIL reset_dc got en=%h we=%h row=%0d want all 0", dc_en, dc_we, dc_row); end
    checks++; if ({dump_busy, dump_valid, dump_done} !== 3'b000 || dump_row !== '0 || dump_data !== '0) begin
      errors++; $display("FAIL reset_dump got busy=%b valid=%b done=%b want 0", dump_busy, dump_valid, dump_done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    req_valid = 2'b01; req_we = 2'b00; req_row[0 +: ROW_W] = 9'd5;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_ready got %b want 01", req_ready); end
    tick();
    idle_inputs();
    checks++; if (dc_en !== 8'hFF || dc_we !== 8'h00 || dc_row !== 9'd5) begin
      errors++; $display("FAIL rd_s1 got en=%h we=%h row=%0d want FF 00 5", dc_en, dc_we, dc_row); end
    tick();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid got %b want 01", rsp_valid); end
    checks++; if (rsp_data !== exp_line(5)) begin errors++; $display("FAIL rd_rsp_data got %h want %h", rsp_data, exp_line(5)); end
    tick(); tick();
  endtask

  task automatic test_masked_write();
    req_valid = 2'b10; req_we = 2'b10; req_row[ROW_W +: ROW_W] = 9'd3;
    req_wmask[NUM_BANKS +: NUM_BANKS] = 8'h81;
    req_wdata[LINE_W +: LINE_W] = {NUM_BANKS{32'hAAAA_AAAA}};
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_ready got %b want 10", req_ready); end
    tick();
    idle_inputs();
    checks++; if (dc_we !== 8'h81 || dc_en !== 8'h81 || dc_row !== 9'd3) begin
      errors++; $display("FAIL wr_s1 got en=%h we=%h row=%0d want 81 81 3", dc_en, dc_we, dc_row); end
    checks++; if (dc_wdata !== {NUM_BANKS{32'hAAAA_AAAA}}) begin errors++; $display("FAIL wr_wdata got %h want AAAA..", dc_wdata); end
    tick();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== '0) begin
      errors++; $display("FAIL wr_ack got valid=%b data=%h want 10 0", rsp_valid, rsp_data); end
    exp_mem[7][3] = 32'hAAAA_AAAA;
    exp_mem[0][3] = 32'hAAAA_AAAA;
    tick();
    // Read row 3 back through requester 1 to see only banks 7 and 0 changed.
    req_valid = 2'b10; req_we = 2'b00; req_row[ROW_W +: ROW_W] = 9'd3;
    tick();
    idle_inputs();
    tick();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== exp_line(3)) begin
      errors++; $display("FAIL wr_readback got valid=%b data=%h want 10 %h", rsp_valid, rsp_data, exp_line(3)); end
    tick(); tick();
  endtask

  task automatic test_contention();
    int n0, n1;
    logic [1:0] exp_rdy, exp_rsp;
    logic [LINE_W-1:0] exp_d;
    n0 = 0; n1 = 0;
    req_row = {9'd20, 9'd10};
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 2'b11 : 2'b00;
      #1;
      exp_rdy = (k < 6) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL cont_ready k=%0d got %b want %b", k, req_ready, exp_rdy); end
      exp_rsp = (k >= 2) ? (((k - 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_d   = (exp_rsp == 2'b01) ? exp_line(10) : (exp_rsp == 2'b10) ? exp_line(20) : '0;
      checks++; if (rsp_valid !== exp_rsp || rsp_data !== exp_d) begin
        errors++; $display("FAIL cont_rsp k=%0d got %b %h want %b %h", k, rsp_valid, rsp_data, exp_rsp, exp_d); end
      if (rsp_valid[0] === 1'b1) n0++;
      if (rsp_valid[1] === 1'b1) n1++;
      tick();
    end
    idle_inputs();
    checks++; if (n0 != 3 || n1 != 3) begin errors++; $display("FAIL cont_count got %0d/%0d want 3/3", n0, n1); end
    tick();
  endtask

  task automatic test_wmask_zero();
    req_valid = 2'b01; req_we = 2'b01; req_row[0 +: ROW_W] = 9'd7;
    req_wmask[0 +: NUM_BANKS] = 8'h00; req_wdata[0 +: LINE_W] = {NUM_BANKS{32'h5555_5555}};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wm0_ready got %b want 01", req_ready); end
    tick();
    idle_inputs();
    checks++; if (dc_en !== 8'h00 || dc_we !== 8'h00) begin errors++; $display("FAIL wm0_en got en=%h we=%h want 0", dc_en, dc_we); end
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== '0) begin
      errors++; $display("FAIL wm0_ack got %b %h want 01 0", rsp_valid, rsp_data); end
    tick(); tick();
  endtask

  task automatic test_dump_during_traffic();
    int beat, cyc, last_cyc;
    bit done;
    logic [1:0] exp_rdy;
    // Two reads in flight (req0 row 1, then req1 row 2), then dump_start.
    req_valid = 2'b01; req_row = {9'd2, 9'd1};
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = 2'b01; dump_start = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL dump_prio_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== exp_line(1)) begin
      errors++; $display("FAIL dump_inflight0 got %b %h want 01", rsp_valid, rsp_data); end
    tick();
    dump_start = 1'b0;
    checks++; if (dump_busy !== 1'b1 || req_ready !== 2'b00) begin
      errors++; $display("FAIL dump_busy got busy=%b ready=%b want 1 00", dump_busy, req_ready); end
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== exp_line(2)) begin
      errors++; $display("FAIL dump_inflight1 got %b %h want 10", rsp_valid, rsp_data); end
    beat = 0; cyc = 0; last_cyc = -10; done = 0;
    while (!done && cyc < 700) begin
      tick();
      cyc++;
      dump_start = (cyc == 50);
      exp_rdy = (beat == ROWS && cyc == last_cyc + 1) ? 2'b01 : 2'b00;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL dump_ready cyc=%0d got %b want %b", cyc, req_ready, exp_rdy); end
      if (dump_valid === 1'b1) begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL dump_overlap got rsp_valid=%b want 00", rsp_valid); end
        checks++; if (dump_row !== ROW_W'(beat) || dump_data !== exp_line(beat)) begin
          errors++; $display("FAIL dump_beat got row=%0d data=%h want row=%0d data=%h", dump_row, dump_data, beat, exp_line(beat)); end
        beat++;
        last_cyc = cyc;
      end
      if (dump_done === 1'b1) begin
        checks++; if (beat != ROWS || cyc != last_cyc + 1) begin
          errors++; $display("FAIL dump_done_timing got beats=%0d gap=%0d want %0d 1", beat, cyc - last_cyc, ROWS); end
        checks++; if (dump_busy !== 1'b0) begin errors++; $display("FAIL dump_busy_end got %b want 0", dump_busy); end
        done = 1;
        req_valid = 2'b00;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL dump_timeout got beats=%0d want done", beat); end
    idle_inputs();
    tick();
    checks++; if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
      errors++; $display("FAIL dump_after got done=%b busy=%b want 0 0", dump_done, dump_busy); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_dump();
    int cyc;
    bit hit, saw_done;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    cyc = 0; hit = 0;
    while (!hit && cyc < 300) begin
      tick();
      cyc++;
      if (dump_valid === 1'b1 && dump_row === 9'd100) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstdump_reach got no row 100 want row 100"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({dump_busy, dump_valid, dump_done} !== 3'b000 || dump_row !== '0 || dump_data !== '0) begin
      errors++; $display("FAIL rstdump_dump got busy=%b valid=%b done=%b want 0", dump_busy, dump_valid, dump_done); end
    checks++; if (dc_en !== 8'h00 || rsp_valid !== 2'b00 || req_ready !== 2'b00 || rsp_data !== '0) begin
      errors++; $display("FAIL rstdump_port got en=%h rsp=%b ready=%b want 0", dc_en, rsp_valid, req_ready); end
    saw_done = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) saw_done = 1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rstdump_nodone got activity want none"); end
    req_valid = 2'b01; req_we = 2'b00; req_row[0 +: ROW_W] = 9'd100;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstdump_rd_ready got %b want 01", req_ready); end
    tick();
    idle_inputs();
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== exp_line(100)) begin
      errors++; $display("FAIL rstdump_rd got %b %h want 01 %h", rsp_valid, rsp_data, exp_line(100)); end
    tick(); tick();
  endtask

`ifdef DC_ARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_row = {9'd1, 9'd2};
    for (int k = 0; k < 8; k++) begin
      req_valid = 2'b11;
      tick();
    end
    idle_inputs();
    tick();
    checks++; if (perf_stall_cnt[32 +: 32] !== 32'd4) begin
      errors++; $display("FAIL perf_cnt1 got %0d want 4", perf_stall_cnt[32 +: 32]); end
    checks++; if (perf_stall_cnt[0 +: 32] !== 32'd4) begin
      errors++; $display("FAIL perf_cnt0 got %0d want 4", perf_stall_cnt[0 +: 32]); end
    tick(); tick();
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rdata_q = '0;
    idle_inputs();
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int r = 0; r < ROWS; r++) begin
        mem[b][r]     = init_word(r, b);
        exp_mem[b][r] = init_word(r, b);
      end
    end
    #1;
    test_reset();
    test_single_read();
    test_masked_write();
    test_contention();
    test_wmask_zero();
    test_dump_during_traffic();
    test_reset_mid_dump();
`ifdef DC_ARB_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
